// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle for uart_rx_cfg: serial line in, character strobe and
// status out, plus the FSM state for observation.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  // o_Rx_DV is a valid-only strobe with no ready: the consumer must take
  // o_Rx_Data and the three error flags in the single cycle o_Rx_DV is high.
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;
  logic [2:0]           state_dbg;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy, state_dbg
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy, state_dbg
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1-2 stops).
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote on every bit sample.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1181,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic           osc_clk,
  input logic           i_Rst,
  uart_rx_cfg_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 samp;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 zero_q, zero_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q, dv_d;
  logic                 perr_o_q, perr_o_d;
  logic                 ferr_o_q, ferr_o_d;
  logic                 brk_o_q, brk_o_d;
  logic                 tick;
  logic                 stop_err;
  logic                 zero_last;

  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // rxs one and two cycles back; the vote rejects a single-cycle glitch
  logic [1:0] hist_q;
  always_ff @(posedge osc_clk) begin
    if (i_Rst) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rxs};
  end
  assign samp = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rxs;
`endif

  assign tick = (cnt_q == FULL_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    par_d     = par_q;
    zero_d    = zero_q;
    ferr_d    = ferr_q;
    dv_d      = 1'b0;
    perr_o_d  = 1'b0;
    ferr_o_d  = 1'b0;
    brk_o_d   = 1'b0;
    stop_err  = ferr_q | ~samp;
    zero_last = zero_q & ~samp;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!samp) begin
            state_d = DATA;
            par_d   = 1'b0;
            zero_d  = 1'b1;
            ferr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shreg_d = {samp, shreg_q[DATA_BITS-1:1]};
          par_d   = par_q ^ samp;
          zero_d  = zero_q & ~samp;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAR: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = par_q ^ samp;
          zero_d  = zero_q & ~samp;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (idx_q == LAST_STOP) begin
            // par_q holds XOR of data and parity bit; even wants 0, odd wants 1
            idx_d    = '0;
            dv_d     = 1'b1;
            data_d   = shreg_q;
            perr_o_d = (PARITY == 1) ? ~par_q : (PARITY == 2) ? par_q : 1'b0;
            ferr_o_d = stop_err;
            brk_o_d  = zero_last;
            state_d  = stop_err ? WAIT_HIGH : IDLE;
          end else begin
            idx_d  = idx_q + IW'(1);
            ferr_d = stop_err;
            zero_d = zero_last;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      zero_q   <= 1'b0;
      ferr_q   <= 1'b0;
      dv_q     <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      brk_o_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], rx.i_Rx_Serial};
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      par_q    <= par_d;
      zero_q   <= zero_d;
      ferr_q   <= ferr_d;
      dv_q     <= dv_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      brk_o_q  <= brk_o_d;
    end
  end

  assign rx.o_Rx_DV      = dv_q;
  assign rx.o_Rx_Data    = data_q;
  assign rx.o_Parity_Err = perr_o_q;
  assign rx.o_Frame_Err  = ferr_o_q;
  assign rx.o_Break      = brk_o_q;
  assign rx.o_Busy       = (state_q != IDLE);
  assign rx.state_dbg    = state_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers in different frame formats, each
// driven with directed and random frames and checked against a frame model.
module tb_uart_rx_cfg;
  localparam int W = 46;

  // clock / reset
  logic osc_clk = 1'b0;
  logic rst     = 1'b1;
  logic rst_q   = 1'b1;
  int   cyc     = 0;
  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  logic line [3];
  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_c ();
  assign if_a.i_Rx_Serial = line[0];
  assign if_b.i_Rx_Serial = line[1];
  assign if_c.i_Rx_Serial = line[2];

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .osc_clk(osc_clk), .i_Rst(rst), .rx(if_a.master));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .osc_clk(osc_clk), .i_Rst(rst), .rx(if_b.master));
  uart_rx_cfg #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
    .osc_clk(osc_clk), .i_Rst(rst), .rx(if_c.master));

  logic       dv   [3];
  logic [8:0] dat  [3];
  logic       perr [3];
  logic       ferr [3];
  logic       brk  [3];
  logic       busy [3];
  assign dv[0] = if_a.o_Rx_DV;  assign dat[0] = {1'b0, if_a.o_Rx_Data};
  assign dv[1] = if_b.o_Rx_DV;  assign dat[1] = {1'b0, if_b.o_Rx_Data};
  assign dv[2] = if_c.o_Rx_DV;  assign dat[2] = {2'b0, if_c.o_Rx_Data};
  assign perr[0] = if_a.o_Parity_Err; assign ferr[0] = if_a.o_Frame_Err; assign brk[0] = if_a.o_Break;
  assign perr[1] = if_b.o_Parity_Err; assign ferr[1] = if_b.o_Frame_Err; assign brk[1] = if_b.o_Break;
  assign perr[2] = if_c.o_Parity_Err; assign ferr[2] = if_c.o_Frame_Err; assign brk[2] = if_c.o_Break;
  assign busy[0] = if_a.o_Busy; assign busy[1] = if_b.o_Busy; assign busy[2] = if_c.o_Busy;

  function automatic int cpb_of(input int d);
    case (d) 0: return 16; 1: return 16; default: return 13; endcase
  endfunction
  function automatic int db_of(input int d);
    return (d == 2) ? 7 : 8;
  endfunction
  function automatic int par_of(input int d);
    case (d) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int sb_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  // scoreboard: {dut[1:0], break, frame_err, parity_err, data[8:0], pulse cycle[31:0]}
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         chk_en = 1'b0;
  logic [8:0]   last_d [3];
  logic [2:0]   last_f [3];
  int           pulses [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    errors++;
    $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Frame model: flags follow directly from the bits put on the wire. The pulse
  // lands 2 sync cycles + 1 edge-notice cycle + half-bit count + 1 register
  // cycle after the start edge, plus (bits-1) whole bit periods.
  function automatic void expect_frame(input int d, input int c, input logic [8:0] data,
                                       input logic pbit, input logic [1:0] stops);
    int nd = db_of(d), np = par_of(d), ns = sb_of(d), cp = cpb_of(d), n;
    logic [8:0] m = '0;
    logic x, pe, fe, sz, bk;
    for (int i = 0; i < nd; i++) m[i] = data[i];
    x  = (^m) ^ pbit;
    pe = (np == 1) ? !x : (np == 2) ? x : 1'b0;
    fe = (ns == 1) ? !stops[0] : !(stops[0] & stops[1]);
    sz = (ns == 1) ? !stops[0] : !(stops[0] | stops[1]);
    bk = (m == 9'd0) && (np == 0 || !pbit) && sz;
    n  = 1 + nd + ((np != 0) ? 1 : 0) + ns;
    exp_q.push_back({2'(d), bk, fe, pe, m, 32'(c + 4 + (cp - 1) / 2 + (n - 1) * cp)});
  endfunction

  // compare process
  always @(negedge osc_clk) begin
    logic [W-1:0] e;
    if (rst_q) begin
      for (int i = 0; i < 3; i++) last_d[i] = 9'd0;
    end else if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (dv[i]) begin
          pulses[i]++;
          last_f[i] = {brk[i], ferr[i], perr[i]};
          if (exp_q.size() == 0 || int'(exp_q[0][45:44]) != i) begin
            note_fail($sformatf("unexpected_pulse_dut%0d", i), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("rx_data_dut%0d", i), 32'(dat[i]), 32'(e[40:32]));
            check($sformatf("flags_brk_fe_pe_dut%0d", i), 32'(last_f[i]), 32'(e[43:41]));
            check($sformatf("pulse_cycle_dut%0d", i), cyc, e[31:0]);
            last_d[i] = e[40:32];
          end
        end else begin
          check($sformatf("flags_off_dut%0d", i), 32'({brk[i], ferr[i], perr[i]}), 32'd0);
        end
        check($sformatf("data_hold_dut%0d", i), 32'(dat[i]), 32'(last_d[i]));
      end
      if (exp_q.size() != 0 && cyc > int'(exp_q[0][31:0])) begin
        e = exp_q.pop_front();
        note_fail($sformatf("missing_pulse_dut%0d", e[45:44]), 32'd0, e[31:0]);
      end
    end
  end

  // driver tasks (always entered and left on a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int gap, input int glitch);
    logic bits[$];
    int cp = cpb_of(d);
    bits.push_back(1'b0);
    for (int i = 0; i < db_of(d); i++) bits.push_back(data[i]);
    if (par_of(d) != 0) bits.push_back(pbit);
    for (int i = 0; i < sb_of(d); i++) bits.push_back(stops[i]);
    expect_frame(d, cyc, data, pbit, stops);
    for (int j = 0; j < bits.size(); j++) begin
      for (int t = 0; t < cp; t++) begin
        line[d] = (j == glitch && t == (cp - 1) / 2 + 1) ? ~bits[j] : bits[j];
        @(negedge osc_clk);
      end
    end
    line[d] = 1'b1;
    idle(gap * cp);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (200000) @(posedge osc_clk);
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p;
    logic [8:0] rd;
    logic [1:0] st;
    int gap;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1; pulses[i] = 0; last_d[i] = '0; last_f[i] = '0;
    end
    idle(4);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs_dut%0d", i),
            32'({dv[i], busy[i], perr[i], ferr[i], brk[i], dat[i]}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(4);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 2, -1);
    drain(400);
    check("t1_pulse_count", pulses[0], 1);
    check("t1_data_literal", 32'(dat[0]), 32'h0A5);
    check("t1_flags_literal", 32'(last_f[0]), 32'd0);

    // even parity 0x3C, correct then wrong parity bit
    send_frame(1, 9'h03C, 1'b0, 2'b11, 1, -1);
    drain(400);
    check("t2_good_parity", 32'(last_f[1]), 32'b000);
    send_frame(1, 9'h03C, 1'b1, 2'b11, 1, -1);
    drain(400);
    check("t2_bad_parity", 32'(last_f[1]), 32'b001);
    check("t2_data_literal", 32'(dat[1]), 32'h03C);

    // stop bit low, line held low three more bit times
    p = pulses[0];
    send_frame(0, 9'h055, 1'b0, 2'b00, 0, -1);
    line[0] = 1'b0;
    idle(3 * 16);
    check("t3_busy_while_low", 32'(busy[0]), 32'd1);
    check("t3_frame_err_literal", 32'(last_f[0]), 32'b010);
    line[0] = 1'b1;
    idle(5);
    check("t3_busy_released", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h012, 1'b0, 2'b11, 1, -1);
    drain(400);
    check("t3_pulse_count", pulses[0] - p, 2);

    // break: line low 30 bit times
    p = pulses[0];
    expect_frame(0, cyc, 9'd0, 1'b0, 2'b00);
    line[0] = 1'b0;
    idle(30 * 16);
    check("t4_one_pulse", pulses[0] - p, 1);
    check("t4_break_flags", 32'(last_f[0]), 32'b110);
    check("t4_busy_low_line", 32'(busy[0]), 32'd1);
    line[0] = 1'b1;
    idle(10);
    check("t4_busy_released", 32'(busy[0]), 32'd0);
    check("t4_no_extra_pulse", pulses[0] - p, 1);

    // 4-cycle glitch, then reset in data bit 3 of 0xFF
    p = pulses[0];
    line[0] = 1'b0;
    idle(4);
    line[0] = 1'b1;
    idle(40);
    check("t5_glitch_no_pulse", pulses[0] - p, 0);
    check("t5_glitch_busy", 32'(busy[0]), 32'd0);
    line[0] = 1'b0;
    idle(16);
    line[0] = 1'b1;
    idle(3 * 16 + 8);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t5_reset_busy", 32'(busy[0]), 32'd0);
    check("t5_reset_data_cleared", 32'(dat[0]), 32'd0);
    idle(16 * 8);
    check("t5_reset_no_pulse", pulses[0] - p, 0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1, -1);
    drain(400);
    check("t5_after_reset_data", 32'(dat[0]), 32'h081);

    // 7O2 0x41 three times back to back
    p = pulses[2];
    for (int k = 0; k < 3; k++) send_frame(2, 9'h041, 1'b1, 2'b11, 0, -1);
    drain(400);
    check("t6_three_pulses", pulses[2] - p, 3);
    check("t6_flags_literal", 32'(last_f[2]), 32'd0);
    check("t6_data_literal", 32'(dat[2]), 32'h041);
`ifdef UART_RX_MAJORITY_EN
    send_frame(2, 9'h041, 1'b1, 2'b11, 1, 3);
    drain(400);
    check("t6_glitch_rejected", 32'(dat[2]), 32'h041);
`endif

    // random frames, one receiver at a time
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 15; k++) begin
        rd  = 9'($urandom_range(0, (1 << db_of(d)) - 1));
        st  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        gap = $urandom_range(0, 2);
        if (st[sb_of(d) - 1] == 1'b0 && gap == 0) gap = 1;
        send_frame(d, rd, 1'($urandom_range(0, 1)), st, gap, -1);
      end
      drain(600);
    end

    idle(20);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
